// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner for a multi-digit BCD result plus carry.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Digits,
    input  logic                    Carry_in,
    output logic [6:0]              Segments,
    output logic [NUM_DIGITS-1:0]   Anode,
    output logic                    DP
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic                    carry_q, carry_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_carry_q, pend_carry_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    dp_q, dp_d;

    logic                    tick;
    logic                    wrap;
    logic [3:0]              cur_digit;
    logic [NUM_DIGITS-1:0]   blank;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b1000000;
            4'd1:    decode = 7'b1111001;
            4'd2:    decode = 7'b0100100;
            4'd3:    decode = 7'b0110000;
            4'd4:    decode = 7'b0011001;
            4'd5:    decode = 7'b0010010;
            4'd6:    decode = 7'b0000010;
            4'd7:    decode = 7'b1111000;
            4'd8:    decode = 7'b0000000;
            4'd9:    decode = 7'b0010000;
            default: decode = 7'b0111111;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the MSD; a digit blanks while it and everything above it is zero.
    always_comb begin
        logic zero_above;
        blank      = '0;
        zero_above = 1'b1;
        for (int unsigned i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above = zero_above & (disp_q[4*i +: 4] == 4'd0);
            blank[i]   = zero_above & ~((i == NUM_DIGITS - 1) & carry_q);
        end
    end
`else
    assign blank = '0;
`endif

    assign tick      = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign wrap      = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));
    assign cur_digit = disp_q[4*idx_q +: 4];

    always_comb begin
        div_d        = tick ? '0 : div_q + DIV_W'(1);
        idx_d        = idx_q;
        disp_d       = disp_q;
        carry_d      = carry_q;
        pend_d       = pend_q;
        pend_carry_d = pend_carry_q;
        pend_valid_d = pend_valid_q;

        if (tick) begin
            idx_d = wrap ? '0 : idx_q + IDX_W'(1);
        end

        // Commit uses the pending value from before this cycle's Load, so a Load
        // arriving in the commit cycle is kept for the following frame.
        if (wrap && pend_valid_q) begin
            disp_d       = pend_q;
            carry_d      = pend_carry_q;
            pend_valid_d = 1'b0;
        end
        if (Load) begin
            pend_d       = Digits;
            pend_carry_d = Carry_in;
            pend_valid_d = 1'b1;
        end

        if (blank[idx_q]) begin
            seg_d   = 7'h7F;
            anode_d = '1;
            dp_d    = 1'b1;
        end else begin
            seg_d   = decode(cur_digit);
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            dp_d    = ~((idx_q == IDX_W'(NUM_DIGITS - 1)) & carry_q);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            carry_q      <= 1'b0;
            pend_q       <= '0;
            pend_carry_q <= 1'b0;
            pend_valid_q <= 1'b0;
            seg_q        <= 7'h7F;
            anode_q      <= '1;
            dp_q         <= 1'b1;
        end else begin
            div_q        <= div_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            carry_q      <= carry_d;
            pend_q       <= pend_d;
            pend_carry_q <= pend_carry_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            anode_q      <= anode_d;
            dp_q         <= dp_d;
        end
    end

    assign Segments = seg_q;
    assign Anode    = anode_q;
    assign DP       = dp_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (NUM_DIGITS=4, REFRESH_DIV=4); honours LEADING_ZERO_BLANK_EN.
module tb_bcd_display_scanner;

    localparam int ND = 4;
    localparam int RD = 4;

    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] S6   = 7'b0000010;
    localparam logic [6:0] S7   = 7'b1111000;
    localparam logic [6:0] S8   = 7'b0000000;
    localparam logic [6:0] S9   = 7'b0010000;
    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] BLK  = 7'h7F;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Load;
    logic [15:0] Digits;
    logic        Carry_in;
    logic [6:0]  Segments;
    logic [3:0]  Anode;
    logic        DP;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0]     digits;
        logic            carry;
        logic [3:0][6:0] seg;
        logic [3:0]      blank;
    } vec_t;

    vec_t vecs[8];
    vec_t sb[$];
    vec_t zero_f;
    vec_t prev;

    always #5 Clock = ~Clock;

    bcd_display_scanner #(
        .NUM_DIGITS (ND),
        .REFRESH_DIV(RD)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Load    (Load),
        .Digits  (Digits),
        .Carry_in(Carry_in),
        .Segments(Segments),
        .Anode   (Anode),
        .DP      (DP)
    );

    function automatic vec_t mk(input logic [15:0] d, input logic c,
                                input logic [6:0] s3, input logic [6:0] s2,
                                input logic [6:0] s1, input logic [6:0] s0,
                                input logic [3:0] b);
        vec_t v;
        v.digits = d;
        v.carry  = c;
        v.seg    = {s3, s2, s1, s0};
        v.blank  = b;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic wait_anode(input logic [3:0] a, input bit want_eq);
        int n = 0;
        while (((Anode == a) != want_eq) && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if ((Anode == a) != want_eq) begin
            checks++;
            errors++;
            $display("FAIL wait_anode timeout: got %b waiting for %b eq=%0d", Anode, a, want_eq);
        end
    endtask

    task automatic wait_frame_start();
        wait_anode(4'b1110, 1'b0);
        wait_anode(4'b1110, 1'b1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic c);
        Digits   = d;
        Carry_in = c;
        Load     = 1'b1;
        @(negedge Clock);
        Load     = 1'b0;
    endtask

    // Pops the next expected frame and compares every cycle of the next complete frame.
    task automatic check_next_frame(input string tag);
        vec_t       f;
        logic [3:0] one;
        logic [3:0] ea;
        logic       edp;
        int         slot;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty got 0 entries expected >=1", tag);
            return;
        end
        f   = sb.pop_front();
        one = 4'b0001;
        wait_frame_start();
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge Clock);
            slot = k / 4;
            ea   = f.blank[slot] ? 4'hF : ~(one << slot);
            edp  = (slot == 3 && f.carry && !f.blank[slot]) ? 1'b0 : 1'b1;
            check($sformatf("%s %h slot%0d cyc%0d {anode,seg,dp}", tag, f.digits, slot, k % 4),
                  {4'h0, Anode, Segments, DP}, {4'h0, ea, f.seg[slot], edp});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset    = 1'b1;
        Load     = 1'b0;
        Digits   = '0;
        Carry_in = 1'b0;

        vecs[0] = mk(16'h1234, 1'b0, S1, S2, S3, S4, 4'b0000);
        vecs[1] = mk(16'h9999, 1'b1, S9, S9, S9, S9, 4'b0000);
        vecs[2] = mk(16'h5678, 1'b0, S5, S6, S7, S8, 4'b0000);
        vecs[6] = mk(16'h1000, 1'b1, S1, S0, S0, S0, 4'b0000);
`ifdef LEADING_ZERO_BLANK_EN
        vecs[3] = mk(16'h00AF, 1'b0, BLK, BLK, DASH, DASH, 4'b1100);
        vecs[4] = mk(16'h0005, 1'b0, BLK, BLK, BLK, S5, 4'b1110);
        vecs[5] = mk(16'h0BCD, 1'b0, BLK, DASH, DASH, DASH, 4'b1000);
        vecs[7] = mk(16'h0E07, 1'b0, BLK, DASH, S0, S7, 4'b1000);
        zero_f  = mk(16'h0000, 1'b0, BLK, BLK, BLK, S0, 4'b1110);
`else
        vecs[3] = mk(16'h00AF, 1'b0, S0, S0, DASH, DASH, 4'b0000);
        vecs[4] = mk(16'h0005, 1'b0, S0, S0, S0, S5, 4'b0000);
        vecs[5] = mk(16'h0BCD, 1'b0, S0, DASH, DASH, DASH, 4'b0000);
        vecs[7] = mk(16'h0E07, 1'b0, S0, DASH, S0, S7, 4'b0000);
        zero_f  = mk(16'h0000, 1'b0, S0, S0, S0, S0, 4'b0000);
`endif

        // Reset held for three edges, then the first lit digit after release.
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        check("reset {anode,seg,dp}", {4'h0, Anode, Segments, DP}, {4'h0, 4'hF, BLK, 1'b1});
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("post-reset 2nd edge {anode,seg}", {5'h0, Anode, Segments}, {5'h0, 4'b1110, S0});

        sb.push_back(zero_f);
        check_next_frame("idle");
        prev = zero_f;

        // Table: load mid-frame, old frame must persist, next frame shows the new value.
        for (int i = 0; i < 8; i++) begin
            wait_frame_start();
            @(negedge Clock);
            do_load(vecs[i].digits, vecs[i].carry);
            sb.push_back(vecs[i]);
            @(negedge Clock);
            check($sformatf("old frame held after load %h seg", vecs[i].digits),
                  {9'h0, Segments}, {9'h0, prev.seg[0]});
            check_next_frame("vec");
            prev = vecs[i];
        end

        // Overwrite before the wrap, then a Load landing exactly in the commit cycle.
        wait_frame_start();
        @(negedge Clock);
        do_load(16'h1111, 1'b0);
        wait_anode(4'b1011, 1'b1);
        do_load(16'h2222, 1'b0);
        sb.push_back(mk(16'h2222, 1'b0, S2, S2, S2, S2, 4'b0000));
        wait_anode(4'b0111, 1'b1);
        @(negedge Clock);
        @(negedge Clock);
        do_load(16'h3333, 1'b0);
        sb.push_back(mk(16'h3333, 1'b0, S3, S3, S3, S3, 4'b0000));
        check_next_frame("overwrite");
        check_next_frame("commit-cycle load");

        // Reset during digit 2 with a Load pending: pending value must be dropped.
        wait_frame_start();
        wait_anode(4'b1101, 1'b1);
        do_load(16'h4321, 1'b1);
        wait_anode(4'b1011, 1'b1);
        Reset = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        check("mid-frame reset {anode,seg,dp}", {4'h0, Anode, Segments, DP}, {4'h0, 4'hF, BLK, 1'b1});
        Reset = 1'b0;
        sb.push_back(zero_f);
        sb.push_back(zero_f);
        check_next_frame("after reset");
        check_next_frame("pending dropped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
